// File: rtl/frame_row_scheduler.sv
// rtl/frame_row_scheduler.sv - frame read-out address sequencer with vertical border replication
// Optional abort input: FRAME_ROW_SCHED_ABORT_EN.
module frame_row_scheduler #(
   parameter int frame_width  = 10,
   parameter int frame_height = 8,
   parameter int filter_size  = 5,
   parameter int add_cells    = (filter_size - 1) / 2,
   parameter int addr_w       = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef FRAME_ROW_SCHED_ABORT_EN
   input  logic              abort,
`endif
   input  logic [addr_w-1:0] rows_written,
   output logic [addr_w-1:0] o_row,
   output logic [addr_w-1:0] o_col,
   output logic              o_TVALID,
   input  logic              i_TREADY,
   output logic [1:0]        o_TUSER,
   output logic              busy,
   output logic              done
);

   localparam logic [addr_w-1:0] LAST_COL = addr_w'(frame_width - 1);
   localparam logic [addr_w-1:0] LAST_ROW = addr_w'(frame_height + 2 * add_cells - 1);
   localparam logic [addr_w-1:0] ADD      = addr_w'(add_cells);
   localparam logic [addr_w-1:0] LAST_SRC = addr_w'(frame_height - 1);

   typedef enum logic [1:0] {IDLE, WAIT_ROW, ISSUE, DONE} state_t;

   state_t            state_q, state_d;
   logic [addr_w-1:0] out_r_q, out_r_d;
   logic [addr_w-1:0] row_q, row_d;
   logic [addr_w-1:0] col_q, col_d;
   logic [addr_w-1:0] src_row;
   logic              valid_q, valid_d;
   logic              sof_q, sof_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        user_q, user_d;
   logic              abort_w;
   logic              hs;

`ifdef FRAME_ROW_SCHED_ABORT_EN
   assign abort_w = abort && (state_q != IDLE);
`else
   assign abort_w = 1'b0;
`endif

   assign hs = valid_q && i_TREADY;

   // Top and bottom border rows replicate the first and last frame rows.
   always_comb begin
      src_row = out_r_q - ADD;
      if (out_r_q < ADD) begin
         src_row = '0;
      end else if ((out_r_q - ADD) >= LAST_SRC) begin
         src_row = LAST_SRC;
      end
   end

   always_comb begin
      state_d = state_q;
      out_r_d = out_r_q;
      row_d   = row_q;
      col_d   = col_q;
      valid_d = valid_q;
      sof_d   = sof_q;
      user_d  = user_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_ROW;
               out_r_d = '0;
               col_d   = '0;
               sof_d   = 1'b1;
            end
         end
         WAIT_ROW: begin
            if (src_row < rows_written) begin
               state_d = ISSUE;
               row_d   = src_row;
               col_d   = '0;
               valid_d = 1'b1;
               user_d  = {(LAST_COL == '0), sof_q};
            end
         end
         ISSUE: begin
            if (hs) begin
               sof_d = 1'b0;
               if (col_q < LAST_COL) begin
                  col_d  = col_q + 1'b1;
                  user_d = {((col_q + 1'b1) == LAST_COL), 1'b0};
               end else begin
                  valid_d = 1'b0;
                  user_d  = 2'b00;
                  if (out_r_q == LAST_ROW) begin
                     state_d = DONE;
                  end else begin
                     out_r_d = out_r_q + 1'b1;
                     state_d = WAIT_ROW;
                  end
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort wins over a same-cycle handshake; that beat already left.
      if (abort_w) begin
         state_d = IDLE;
         valid_d = 1'b0;
         user_d  = 2'b00;
         col_d   = '0;
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         out_r_q <= '0;
         row_q   <= '0;
         col_q   <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         user_q  <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_r_q <= out_r_d;
         row_q   <= row_d;
         col_q   <= col_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         user_q  <= user_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_row    = row_q;
   assign o_col    = col_q;
   assign o_TVALID = valid_q;
   assign o_TUSER  = user_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_frame_row_scheduler.sv
// tb/tb_frame_row_scheduler.sv - directed self-checking bench for frame_row_scheduler
module tb_frame_row_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] rows_written;
   logic [10:0] o_row;
   logic [10:0] o_col;
   logic        o_TVALID;
   logic        i_TREADY;
   logic [1:0]  o_TUSER;
   logic        busy;
   logic        done;
`ifdef FRAME_ROW_SCHED_ABORT_EN
   logic        abort = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int row_tab [12] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7};

   frame_row_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
`ifdef FRAME_ROW_SCHED_ABORT_EN
      .abort        (abort),
`endif
      .rows_written (rows_written),
      .o_row        (o_row),
      .o_col        (o_col),
      .o_TVALID     (o_TVALID),
      .i_TREADY     (i_TREADY),
      .o_TUSER      (o_TUSER),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Cycle 0 is the cycle carrying the start pulse.
   task automatic run_frame(input bit toggle, input bit timed, input bit stall);
      int          b  = 0;
      int          nd = 0;
      logic        pv = 1'b0;
      logic [10:0] pr = '0;
      logic [10:0] pc = '0;
      logic [1:0]  pu = '0;
      cyc          = 0;
      start        = 1'b1;
      rows_written = stall ? 11'd3 : 11'd8;
      i_TREADY     = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      while (cyc < 400 && nd == 0) begin
         if (stall && cyc == 61) rows_written = 11'd8;
         if (toggle) i_TREADY = (cyc % 2 == 0);
         if (pv) begin
            chk("hold_valid", o_TVALID, 1);
            chk("hold_row", o_row, pr);
            chk("hold_col", o_col, pc);
            chk("hold_user", o_TUSER, pu);
         end
         if (stall && (cyc == 56 || cyc == 61)) chk("stall_valid", o_TVALID, 0);
         if (o_TVALID && i_TREADY) begin
            chk("beat_row", o_row, row_tab[b / 10]);
            chk("beat_col", o_col, b % 10);
            chk("beat_user", o_TUSER, {(b % 10 == 9), (b == 0)});
            if (timed) chk("beat_cycle", cyc, 2 + 11 * (b / 10) + b % 10);
            if (stall && b == 50) chk("stall_row3_cycle", cyc, 62);
            b++;
         end
         if (done) begin
            nd++;
            if (timed) chk("done_cycle", cyc, 133);
            chk("busy_in_done", busy, 1);
         end
         pv = o_TVALID && !i_TREADY;
         pr = o_row;
         pc = o_col;
         pu = o_TUSER;
         start = timed && (cyc == 50 || done);
         step();
      end
      start = 1'b0;
      chk("beats", b, 120);
      chk("done_pulses", nd, 1);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_valid", o_TVALID, 0);
      chk("idle_done", done, 0);
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      rows_written = 11'd8;
      i_TREADY     = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("rst_valid", o_TVALID, 0);
      chk("rst_row", o_row, 0);
      chk("rst_col", o_col, 0);
      chk("rst_user", o_TUSER, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      run_frame(1'b0, 1'b1, 1'b0);
      run_frame(1'b0, 1'b0, 1'b1);
      run_frame(1'b1, 1'b0, 1'b0);

      cyc          = 0;
      start        = 1'b1;
      rows_written = 11'd8;
      i_TREADY     = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 40) step();
      chk("pre_reset_valid", o_TVALID, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_valid", o_TVALID, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      step();
      chk("midrst_done2", done, 0);
      run_frame(1'b0, 1'b0, 1'b0);

`ifdef FRAME_ROW_SCHED_ABORT_EN
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 30) step();
      chk("pre_abort_valid", o_TVALID, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", o_TVALID, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_user", o_TUSER, 0);
      chk("abort_col", o_col, 0);
      step();
      chk("abort_done2", done, 0);
      run_frame(1'b0, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
